mmio_hub: RTL and testbench
===========================

# mmio_hub

Parametrised memory-mapped I/O hub between the CPU memory port (`mem_cmd`/`mem_addr`/`write_data`/`read_data`) and the board: RAM select/write-enable, N_OUT registered output channels (LEDs), and N_IN synchronised, debounced input channels (switches) with a sticky change-status register. It generalises the fixed LED-at-0x100 / switch-at-0x140 decode of the lab top into a configurable address map with read-back, unmapped-read handling and input conditioning. It sits in the top level between `cpu` and `RAM`.

## Interface
- ADDR_W, 9: CPU address width; bit ADDR_W-1 = 0 selects RAM, 1 selects I/O
- DATA_W, 16: CPU data width
- CH_W, 8: width of each I/O channel (CH_W ≤ DATA_W)
- N_OUT, 2: output channels (1..8)
- N_IN, 2: input channels (1..8, ≤ DATA_W)
- OUT_BASE, 9'h100: address of output channel 0; channel k at OUT_BASE+k
- IN_BASE, 9'h140: address of input channel 0; channel k at IN_BASE+k
- STAT_ADDR, 9'h17F: change-status register address
- DB_CYCLES, 4: debounce stability count (≥ 1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset on next rising edge)
- mem_cmd  in  2  MNONE=00, MREAD=01, MWRITE=10
- mem_addr  in  ADDR_W  CPU address
- write_data  in  DATA_W  CPU write data
- ram_data  in  DATA_W  RAM read data (`dout`)
- read_data  out  DATA_W  data returned to CPU
- ram_we  out  1  RAM write enable
- sw_in  in  N_IN*CH_W  asynchronous board inputs, channel k at [k*CH_W +: CH_W]
- led_out  out  N_OUT*CH_W  registered outputs, same packing

## Operation
- Decode (combinational): ram_sel = ~mem_addr[ADDR_W-1]; ram_we = ram_sel & (mem_cmd==MWRITE).
- read_data (combinational, zero latency): RAM region & MREAD → ram_data; OUT_BASE+k → led reg k zero-extended; IN_BASE+k → debounced input k zero-extended; STAT_ADDR → status zero-extended; any other I/O address or non-MREAD → 0. Never high-Z.
- Write: MWRITE to OUT_BASE+k loads write_data[CH_W-1:0] into led reg k. MWRITE to input, status or unmapped I/O addresses is ignored. Address ranges overlapping: output decode wins over input, input over status.
- Input path per channel: 2-flop synchroniser → debouncer → stable reg.
- Debouncer: counter cnt; if sync ≠ stable, cnt++; when cnt reaches DB_CYCLES-1 while still ≠, stable ← sync and cnt ← 0; if sync == stable, cnt ← 0. Whole-channel compare.
- Status bit k sets when stable k changes value. The edge with MREAD at STAT_ADDR clears all bits that read 1; a set in the same cycle wins (bit stays 1).
- Reset: led_out = 0, synchronisers = 0, stable = 0, cnt = 0, status = 0. Reset mid-debounce discards progress. A nonzero switch held through reset produces a change (status set) after the normal latency.

## Timing
- Output write: led_out updates at the edge sampling MWRITE; visible that cycle plus one.
- Input latency, debounce on: sw_in change held steady → stable updates DB_CYCLES+2 edges later; status bit set on the same edge.
- Glitch shorter than DB_CYCLES synchronised cycles → no stable change.
- Reads have no latency and no handshake; status clear takes effect on the read edge.

## Configuration
- MMIO_DEBOUNCE_EN defined: debouncer as above.
- Not defined: stable ← synchroniser output every cycle (latency 2 edges), no counters, DB_CYCLES unused; status behaviour unchanged.

## Structure
- Package `mmio_pkg`: MNONE/MREAD/MWRITE localparams, `mem_cmd_t` typedef, default address-map constants.
- One sub-module `mmio_debounce` (sync + counter + stable reg for one CH_W channel), instantiated N_IN times with a generate loop; decode, output regs and status stay in `mmio_hub`.

## Test plan
- Reset low one edge, then MREAD at 0x100, 0x140, 0x17F → read_data = 0 each; led_out = 0.
- MWRITE 16'hABCD to 0x101 → led_out[15:8] = 8'hCD next cycle; MREAD 0x101 → 16'h00CD; ram_we stays 0.
- sw_in[7:0] = 8'h5A held (debounce on, DB_CYCLES=4) → MREAD 0x140 returns 16'h005A exactly 6 edges later; status = 16'h0001; MREAD 0x17F returns 1, next read returns 0.
- sw_in[7:0] pulse 8'hFF for 2 cycles → stable unchanged, status stays 0.
- Status read on same edge a new change on channel 1 lands → bit 1 remains 1 after the read.
- MWRITE 16'h1234 to 0x020 → ram_we = 1 that cycle; MREAD 0x020 with ram_data = 16'h1234 → read_data = 16'h1234; MREAD unmapped 0x150 → 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared command encodings and default address map for the MMIO hub.
package mmio_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t MNONE  = 2'b00;
  localparam mem_cmd_t MREAD  = 2'b01;
  localparam mem_cmd_t MWRITE = 2'b10;

  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_CH_W      = 8;
  localparam int DEF_N_OUT     = 2;
  localparam int DEF_N_IN      = 2;
  localparam int DEF_DB_CYCLES = 4;

  localparam logic [8:0] DEF_OUT_BASE  = 9'h100;
  localparam logic [8:0] DEF_IN_BASE   = 9'h140;
  localparam logic [8:0] DEF_STAT_ADDR = 9'h17F;

endpackage

// File: rtl/mmio_hub_if.sv
// CPU memory-port bundle: command/address/data from the CPU, RAM read data in,
// read data and RAM write enable back out. No handshake; everything is same-cycle.
interface mmio_hub_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  import mmio_pkg::*;

  mem_cmd_t            mem_cmd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   ram_data;
  logic [DATA_W-1:0]   read_data;
  logic                ram_we;

  modport master (
    output mem_cmd, mem_addr, write_data, ram_data,
    input  read_data, ram_we
  );

  modport slave (
    input  mem_cmd, mem_addr, write_data, ram_data,
    output read_data, ram_we
  );

endinterface

// File: rtl/mmio_debounce.sv
// One input channel: 2-flop synchroniser then (MMIO_DEBOUNCE_EN) stability counter into a stable reg.
// Latency: DB_CYCLES+2 edges with debounce, 2 edges without; chg flags the edge stable will change.
// No backpressure: free-running every cycle.
module mmio_debounce #(
  parameter int CH_W      = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH_W-1:0] din,
  output logic [CH_W-1:0] stable,
  output logic            chg
);

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("mmio_debounce: DB_CYCLES must be >= 1");
  end

  logic [CH_W-1:0] sync1;
  logic [CH_W-1:0] stable_q;

  assign stable = stable_q;

`ifdef MMIO_DEBOUNCE_EN
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CH_W-1:0]  sync2;
  logic [CNT_W-1:0] cnt;
  logic             diff;
  logic             done;

  assign diff = (sync2 != stable_q);
  assign done = (cnt == CNT_W'(DB_CYCLES - 1));
  assign chg  = diff & done;

  // Any whole-channel match restarts the count, so a bouncing input never commits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
      cnt      <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (!diff) begin
        cnt <= '0;
      end else if (done) begin
        stable_q <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  // The stable reg doubles as the second synchroniser flop.
  assign chg = (sync1 != stable_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= '0;
      stable_q <= '0;
    end else begin
      sync1    <= din;
      stable_q <= sync1;
    end
  end
`endif

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: RAM/I-O decode, N_OUT led regs, N_IN conditioned inputs, sticky change status (MMIO_DEBOUNCE_EN enables debounce).
// Latency: reads combinational; led writes visible next cycle; inputs DB_CYCLES+2 edges (2 without debounce).
// No backpressure: every command completes in the cycle it is presented.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                CH_W      = DEF_CH_W,
  parameter int                N_OUT     = DEF_N_OUT,
  parameter int                N_IN      = DEF_N_IN,
  parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(DEF_OUT_BASE),
  parameter logic [ADDR_W-1:0] IN_BASE   = ADDR_W'(DEF_IN_BASE),
  parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DEF_STAT_ADDR),
  parameter int                DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_hub_if.slave               bus,
  input  logic [N_IN*CH_W-1:0]    sw_in,
  output logic [N_OUT*CH_W-1:0]   led_out
);

  if (CH_W > DATA_W || N_IN > DATA_W || N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 8) begin : g_bad_cfg
    $error("mmio_hub: channel configuration out of range");
  end

  logic             ram_sel;
  logic             is_read;
  logic             is_write;
  logic [N_OUT-1:0] out_hit;
  logic [N_IN-1:0]  in_hit;
  logic             stat_hit;
  logic             rd_stat;
  logic [DATA_W-1:0] rd_dat;

  logic [CH_W-1:0]  led_q  [N_OUT];
  logic [CH_W-1:0]  stable [N_IN];
  logic [N_IN-1:0]  chg;
  logic [N_IN-1:0]  status;

  assign ram_sel    = ~bus.mem_addr[ADDR_W-1];
  assign is_read    = (bus.mem_cmd == MREAD);
  assign is_write   = (bus.mem_cmd == MWRITE);
  assign bus.ram_we = ram_sel & is_write;

  // Overlapping ranges resolve output > input > status.
  always_comb begin
    out_hit  = '0;
    in_hit   = '0;
    stat_hit = 1'b0;
    if (!ram_sel) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (bus.mem_addr == OUT_BASE + ADDR_W'(k)) out_hit[k] = 1'b1;
      end
      for (int k = 0; k < N_IN; k++) begin
        if (bus.mem_addr == IN_BASE + ADDR_W'(k)) in_hit[k] = 1'b1;
      end
      stat_hit = (bus.mem_addr == STAT_ADDR);
    end
    if (|out_hit) begin
      in_hit   = '0;
      stat_hit = 1'b0;
    end else if (|in_hit) begin
      stat_hit = 1'b0;
    end
  end

  always_comb begin
    rd_dat = '0;
    if (is_read) begin
      if (ram_sel) begin
        rd_dat = bus.ram_data;
      end else begin
        for (int k = 0; k < N_OUT; k++) begin
          if (out_hit[k]) rd_dat = DATA_W'(led_q[k]);
        end
        for (int k = 0; k < N_IN; k++) begin
          if (in_hit[k]) rd_dat = DATA_W'(stable[k]);
        end
        if (stat_hit) rd_dat = DATA_W'(status);
      end
    end
  end

  assign bus.read_data = rd_dat;
  assign rd_stat       = is_read & stat_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) led_q[k] <= '0;
    end else if (is_write) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (out_hit[k]) led_q[k] <= bus.write_data[CH_W-1:0];
      end
    end
  end

  // A change landing on the clearing read still sets its bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      status <= '0;
    end else begin
      status <= (rd_stat ? '0 : status) | chg;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign led_out[k*CH_W +: CH_W] = led_q[k];
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    mmio_debounce #(
      .CH_W      (CH_W),
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .din    (sw_in[k*CH_W +: CH_W]),
      .stable (stable[k]),
      .chg    (chg[k])
    );
  end

endmodule

// File: tb/tb_mmio_hub.sv
// Randomised bench for mmio_hub against an edge-history model of the address map, led regs,
// input conditioning and sticky status, plus directed literal checks.
`timescale 1ns/1ps
module tb_mmio_hub;
  import mmio_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int CH_W   = 8;
  localparam int N_OUT  = 2;
  localparam int N_IN   = 2;
  localparam int DB     = 4;
`ifdef MMIO_DEBOUNCE_EN
  localparam int LAT = DB + 2;
`else
  localparam int LAT = 2;
`endif
  localparam int MAXE = 8192;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b0;
  logic [N_IN*CH_W-1:0]  sw_in = '0;
  logic [N_OUT*CH_W-1:0] led_out;

  mmio_hub_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mmio_hub #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CH_W      (CH_W),
    .N_OUT     (N_OUT),
    .N_IN      (N_IN),
    .OUT_BASE  (9'h100),
    .IN_BASE   (9'h140),
    .STAT_ADDR (9'h17F),
    .DB_CYCLES (DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [CH_W-1:0] m_led    [N_OUT];
  logic [CH_W-1:0] m_stable [N_IN];
  logic [N_IN-1:0] m_status;
  logic [CH_W-1:0] samp     [N_IN][MAXE];
  int              last_upd [N_IN];
  int              e        = 0;
  int              last_rst = -1;
  bit              m_valid  = 0;

  // Value the conditioning logic has available at edge n (two-flop delay, zero after reset).
  function automatic logic [CH_W-1:0] seen(input int k, input int n);
    if (n - 2 > last_rst) return samp[k][n-2];
    return '0;
  endfunction

  task automatic model_edge();
    logic [N_IN-1:0] chg;
    logic [CH_W-1:0] nv;
    bit              ok;
    int              a;
    if (e >= MAXE) return;
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) m_led[k] = '0;
      for (int k = 0; k < N_IN; k++) begin
        m_stable[k] = '0;
        samp[k][e]  = '0;
        last_upd[k] = e;
      end
      m_status = '0;
      last_rst = e;
      m_valid  = 1;
    end else if (m_valid) begin
      for (int k = 0; k < N_IN; k++) samp[k][e] = sw_in[k*CH_W +: CH_W];
      chg = '0;
      for (int k = 0; k < N_IN; k++) begin
        nv = m_stable[k];
`ifdef MMIO_DEBOUNCE_EN
        ok = 1;
        for (int j = e - DB + 1; j <= e; j++) begin
          if (j <= last_upd[k] || j <= last_rst || seen(k, j) == m_stable[k]) ok = 0;
        end
        if (ok) begin
          nv = seen(k, e);
          last_upd[k] = e;
        end
`else
        nv = (e - 1 > last_rst) ? samp[k][e-1] : '0;
`endif
        if (nv != m_stable[k]) chg[k] = 1'b1;
        m_stable[k] = nv;
      end
      a = int'(bus.mem_addr);
      if (bus.mem_cmd == MWRITE && a >= 'h100 && a < 'h100 + N_OUT)
        m_led[a - 'h100] = bus.write_data[CH_W-1:0];
      if (bus.mem_cmd == MREAD && a == 'h17F) m_status = '0;
      m_status = m_status | chg;
    end
    e++;
  endtask

  function automatic logic [DATA_W-1:0] exp_read();
    int a;
    a = int'(bus.mem_addr);
    if (bus.mem_cmd != MREAD) return '0;
    if (a < 'h100) return bus.ram_data;
    if (a >= 'h100 && a < 'h100 + N_OUT) return DATA_W'(m_led[a - 'h100]);
    if (a >= 'h140 && a < 'h140 + N_IN) return DATA_W'(m_stable[a - 'h140]);
    if (a == 'h17F) return DATA_W'(m_status);
    return '0;
  endfunction

  function automatic logic [N_OUT*CH_W-1:0] exp_led();
    logic [N_OUT*CH_W-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[k*CH_W +: CH_W] = m_led[k];
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model_read_data", 32'(bus.read_data), 32'(exp_read()));
        chk("model_ram_we", 32'(bus.ram_we), 32'(bus.mem_cmd == MWRITE && !bus.mem_addr[8]));
        chk("model_led_out", 32'(led_out), 32'(exp_led()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mem_cmd_t c, input logic [8:0] a, input logic [15:0] wd, input logic [15:0] rd);
    bus.mem_cmd    = c;
    bus.mem_addr   = a;
    bus.write_data = wd;
    bus.ram_data   = rd;
  endtask

  logic [8:0] alist [11] = '{9'h020, 9'h0FF, 9'h100, 9'h101, 9'h102, 9'h140,
                             9'h141, 9'h142, 9'h17F, 9'h150, 9'h1C0};

  initial begin
    drive(MNONE, 9'h000, 16'h0, 16'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;

    drive(MREAD, 9'h100, 16'h0, 16'hFFFF);
    @(negedge clk);
    chk("rst_rd_led", 32'(bus.read_data), 32'h0);
    chk("rst_led_out", 32'(led_out), 32'h0);
    step();
    drive(MREAD, 9'h140, 16'h0, 16'hFFFF);
    @(negedge clk);
    chk("rst_rd_sw", 32'(bus.read_data), 32'h0);
    step();
    drive(MREAD, 9'h17F, 16'h0, 16'hFFFF);
    @(negedge clk);
    chk("rst_rd_stat", 32'(bus.read_data), 32'h0);

    step();
    drive(MWRITE, 9'h101, 16'hABCD, 16'h0);
    @(negedge clk);
    chk("led_wr_ram_we", 32'(bus.ram_we), 32'h0);
    step();
    drive(MREAD, 9'h101, 16'h0, 16'h0);
    @(negedge clk);
    chk("led_out_ch1", 32'(led_out[15:8]), 32'hCD);
    chk("led_rd_ch1", 32'(bus.read_data), 32'h00CD);

    step();
    drive(MNONE, 9'h000, 16'h0, 16'h0);
    sw_in[7:0] = 8'h5A;
    repeat (LAT - 1) step();
    drive(MREAD, 9'h140, 16'h0, 16'h0);
    @(negedge clk);
    chk("sw_before_lat", 32'(bus.read_data), 32'h0);
    step();
    @(negedge clk);
    chk("sw_at_lat", 32'(bus.read_data), 32'h005A);
    step();
    drive(MREAD, 9'h17F, 16'h0, 16'h0);
    @(negedge clk);
    chk("stat_set", 32'(bus.read_data), 32'h0001);
    step();
    @(negedge clk);
    chk("stat_cleared", 32'(bus.read_data), 32'h0);

    step();
    drive(MNONE, 9'h000, 16'h0, 16'h0);
    sw_in[7:0] = 8'hFF;
    step();
    step();
    sw_in[7:0] = 8'h5A;
    repeat (LAT + 4) step();
    drive(MREAD, 9'h140, 16'h0, 16'h0);
    @(negedge clk);
    chk("glitch_stable", 32'(bus.read_data), 32'h005A);
    step();
    drive(MREAD, 9'h17F, 16'h0, 16'h0);
    @(negedge clk);
`ifdef MMIO_DEBOUNCE_EN
    chk("glitch_stat", 32'(bus.read_data), 32'h0);
`else
    chk("glitch_stat", 32'(bus.read_data), 32'h0001);
`endif
    step();
    drive(MNONE, 9'h000, 16'h0, 16'h0);
    sw_in[15:8] = 8'h33;
    repeat (LAT - 1) step();
    drive(MREAD, 9'h17F, 16'h0, 16'h0);
    @(negedge clk);
    chk("race_pre", 32'(bus.read_data), 32'h0);
    step();
    @(negedge clk);
    chk("race_bit_kept", 32'(bus.read_data), 32'h0002);
    step();
    @(negedge clk);
    chk("race_cleared", 32'(bus.read_data), 32'h0);

    step();
    drive(MWRITE, 9'h020, 16'h1234, 16'h0);
    @(negedge clk);
    chk("ram_we_on", 32'(bus.ram_we), 32'h1);
    chk("ram_wr_rd0", 32'(bus.read_data), 32'h0);
    step();
    drive(MREAD, 9'h020, 16'h0, 16'h1234);
    @(negedge clk);
    chk("ram_rd", 32'(bus.read_data), 32'h1234);
    chk("ram_rd_we", 32'(bus.ram_we), 32'h0);
    step();
    drive(MREAD, 9'h150, 16'h0, 16'hBEEF);
    @(negedge clk);
    chk("unmapped_rd", 32'(bus.read_data), 32'h0);

    step();
    drive(MNONE, 9'h000, 16'h0, 16'h0);
    sw_in[7:0] = 8'h77;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (LAT - 1) step();
    drive(MREAD, 9'h140, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst_mid_early", 32'(bus.read_data), 32'h0);
    step();
    @(negedge clk);
    chk("rst_mid_lat", 32'(bus.read_data), 32'h0077);
    step();
    drive(MREAD, 9'h17F, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst_mid_stat", 32'(bus.read_data), 32'h0003);

    for (int i = 0; i < 3000; i++) begin
      int r;
      step();
      reset = ($urandom_range(0, 299) != 0);
      r = $urandom_range(0, 9);
      drive((r < 2) ? MNONE : (r < 6) ? MREAD : (r < 9) ? MWRITE : mem_cmd_t'(2'b11),
            (($urandom_range(0, 5) == 0) ? 9'($urandom) : alist[$urandom_range(0, 10)]),
            16'($urandom), 16'($urandom));
      for (int k = 0; k < N_IN; k++) begin
        if ($urandom_range(0, 7) == 0) sw_in[k*CH_W +: CH_W] = 8'($urandom);
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
